note_priority_decoder: RTL and testbench
========================================

NOTE_PRIORITY_DECODER -- requirements
Module: note_priority_decoder

Interface
REQ-001 SHALL have parameter N_KEYS, default 24, number of touch channels (2..32).
REQ-002 SHALL have parameter DB_CYCLES, default 16, debounce stability count in clk_in cycles (1..65535).
REQ-003 SHALL have parameter PRIO_MODE, default PRIO_LAST, monophonic selection mode (PRIO_LAST, PRIO_LOW, PRIO_HIGH).
REQ-004 SHALL derive localparams SEL_W = $clog2(N_KEYS) and CNT_W = $clog2(N_KEYS+1).
REQ-005 clk_in  input  1  sole clock, all logic on posedge.
REQ-006 rst_n_in  input  1  reset, synchronous, active-low.
REQ-007 touch_status_in  input  N_KEYS  raw per-key touch level, bit i = key i.
REQ-008 gate_out  output  N_KEYS  clean held level per key.
REQ-009 trigger_out  output  N_KEYS  one-cycle pulse on gate rising edge.
REQ-010 release_out  output  N_KEYS  one-cycle pulse on gate falling edge.
REQ-011 note_sel_out  output  SEL_W  index of selected key.
REQ-012 note_valid_out  output  1  high while at least one gate is held.
REQ-013 note_change_out  output  1  one-cycle pulse when note_sel_out changes or note_valid_out rises.
REQ-014 active_count_out  output  CNT_W  popcount of gate_out.

Function
REQ-015 SHALL register touch_status_in once before any use; gate_out latency without debounce = 1 cycle from input edge.
REQ-016 trigger_out[i] SHALL be high in exactly the cycle gate_out[i] goes 0->1; release_out[i] exactly the cycle it goes 1->0; never both.
REQ-017 active_count_out SHALL be combinational popcount of registered gate_out (same cycle as gate).
REQ-018 note_sel_out, note_valid_out, note_change_out SHALL be registered, updating one cycle after the gate_out change that causes them.
REQ-019 PRIO_LOW: selected = lowest-indexed held key; PRIO_HIGH: highest-indexed held key.
REQ-020 PRIO_LAST: any trigger selects the triggering key; multiple triggers in one cycle -> lowest index among them.
REQ-021 PRIO_LAST: release of the selected key with others held -> fall back to lowest-indexed held key; release of a non-selected key -> no change.
REQ-022 PRIO_LAST: press and release on different keys in same cycle -> press wins.
REQ-023 All gates low -> note_valid_out = 0, note_sel_out holds last value (release tail for playback), no note_change_out.
REQ-024 note_change_out SHALL NOT pulse when re-selection yields the same index.

Reset
REQ-025 rst_n_in low at a clock edge SHALL clear input register, gate_out, debounce counters, note_sel_out, note_valid_out, note_change_out to 0.
REQ-026 trigger_out/release_out SHALL be 0 during and the first cycle after reset; keys held across reset release SHALL trigger once as fresh presses (after debounce).
REQ-027 Reset asserted mid-debounce SHALL discard partial counts.

Configuration
REQ-028 Macro NOTE_DEBOUNCE_EN defined: gate_out[i] toggles only after registered input differs from gate_out[i] for DB_CYCLES consecutive cycles; any agreeing cycle resets that key's counter to 0.
REQ-029 NOTE_DEBOUNCE_EN undefined: gate_out = registered input, no counters instantiated, DB_CYCLES ignored.

Structure
REQ-030 Package note_pkg SHALL hold enum prio_mode_t {PRIO_LAST, PRIO_LOW, PRIO_HIGH} and constant MAX_KEYS = 32.
REQ-031 Sub-module key_debouncer (one instance per key, generate loop) SHALL hold the per-key counter and clean level; present only under NOTE_DEBOUNCE_EN.
REQ-032 Priority logic SHALL stay in the top module; no further sub-modules.

Verification
REQ-033 No debounce, PRIO_LOW: input 0x000014 held -> gate_out 0x000014 after 1 cycle, trigger_out 0x000014 one cycle, note_sel_out=2, valid=1, active_count_out=2.
REQ-034 PRIO_LAST: press key 5, then key 3, then release 3 -> note_sel_out 5,3,5 with note_change_out pulse at each change.
REQ-035 PRIO_LAST: keys 7 and 4 triggered same cycle -> note_sel_out=4; release all -> valid=0, note_sel_out stays 4, release_out 0x000090 one cycle.
REQ-036 NOTE_DEBOUNCE_EN, DB_CYCLES=4: key 0 pulses high 3 cycles -> no gate change; high 6 cycles -> gate rises after 4 stable cycles, trigger once.
REQ-037 Key 10 held, rst_n_in low 2 cycles mid-hold -> all outputs 0 in reset; after release of reset, trigger_out[10] pulses once, note_sel_out=10.
REQ-038 PRIO_HIGH, N_KEYS=8: input 0x81 -> note_sel_out=7; drop bit 7 -> note_sel_out=0 with note_change_out pulse.

Source files
------------

// File: rtl/note_pkg.sv
// Shared types and helpers for the touch-key note priority decoder.
//   prio_mode_t  : monophonic selection policy
//   MAX_KEYS     : upper bound on the number of touch channels
//   lowest_set / highest_set : priority encoders over a MAX_KEYS-wide vector
package note_pkg;

   typedef enum logic [1:0] {PRIO_LAST, PRIO_LOW, PRIO_HIGH} prio_mode_t;

   localparam int MAX_KEYS = 32;
   localparam int IDX_W    = $clog2(MAX_KEYS);

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_KEYS-1:0] v);
      lowest_set = '0;
      for (int i = MAX_KEYS - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = IDX_W'(i);
      end
   endfunction

   // Index of the highest set bit; 0 when the vector is empty.
   function automatic logic [IDX_W-1:0] highest_set(input logic [MAX_KEYS-1:0] v);
      highest_set = '0;
      for (int i = 0; i < MAX_KEYS; i++) begin
         if (v[i]) highest_set = IDX_W'(i);
      end
   endfunction

endpackage

// File: rtl/note_priority_decoder_key_debouncer.sv
// key_debouncer: per-key stability filter used when NOTE_DEBOUNCE_EN is defined.
//   clk_in    : clock
//   rst_n_in  : synchronous active-low reset (clears count and level)
//   raw       : registered touch level for this key
//   level     : clean level, follows raw after DB_CYCLES consecutive
//               disagreeing samples
module key_debouncer
   import note_pkg::*;
#(
   parameter int DB_CYCLES = 16
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic raw,
   output logic level
);

   localparam int W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(DB_CYCLES - 1);

   logic [W-1:0] cnt;

   // Any agreeing sample restarts the run; the DB_CYCLES-th disagreeing
   // sample flips the level.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (raw == level) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt   <= '0;
         level <= raw;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/note_priority_decoder.sv
// note_priority_decoder: turns raw capacitive-touch levels into clean gates,
// edge pulses and a single monophonic note selection.
//   clk_in           : sole clock
//   rst_n_in         : synchronous active-low reset
//   touch_status_in  : raw touch level per key
//   gate_out         : clean held level per key
//   trigger_out      : one-cycle pulse on gate rise
//   release_out      : one-cycle pulse on gate fall
//   note_sel_out     : selected key index (held after all keys release)
//   note_valid_out   : at least one gate held
//   note_change_out  : pulse when selection changes or valid rises
//   active_count_out : number of held gates
// Optional feature: define NOTE_DEBOUNCE_EN to insert a key_debouncer per key.
module note_priority_decoder
   import note_pkg::*;
#(
   parameter  int         N_KEYS    = 24,
   parameter  int         DB_CYCLES = 16,
   parameter  prio_mode_t PRIO_MODE = PRIO_LAST,
   localparam int         SEL_W     = $clog2(N_KEYS),
   localparam int         CNT_W     = $clog2(N_KEYS + 1)
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [N_KEYS-1:0] touch_status_in,
   output logic [N_KEYS-1:0] gate_out,
   output logic [N_KEYS-1:0] trigger_out,
   output logic [N_KEYS-1:0] release_out,
   output logic [SEL_W-1:0]  note_sel_out,
   output logic              note_valid_out,
   output logic              note_change_out,
   output logic [CNT_W-1:0]  active_count_out
);

   if (N_KEYS < 2 || N_KEYS > MAX_KEYS || DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_param_check
      $error("note_priority_decoder: N_KEYS or DB_CYCLES out of range");
   end

   logic [N_KEYS-1:0]   touch_p0;
   logic [N_KEYS-1:0]   gate_p1;
   logic [MAX_KEYS-1:0] gate_ext;
   logic [MAX_KEYS-1:0] trig_ext;
   logic [IDX_W-1:0]    low_full;
   logic [IDX_W-1:0]    high_full;
   logic [IDX_W-1:0]    trig_full;
   logic [SEL_W-1:0]    next_sel;
   logic                next_valid;
   logic                next_change;

   // Stage p0: input capture
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) touch_p0 <= '0;
      else           touch_p0 <= touch_status_in;
   end

`ifdef NOTE_DEBOUNCE_EN
   for (genvar i = 0; i < N_KEYS; i++) begin : g_db
      key_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk_in   (clk_in),
         .rst_n_in (rst_n_in),
         .raw      (touch_p0[i]),
         .level    (gate_out[i])
      );
   end
`else
   assign gate_out = touch_p0;
`endif

   // Stage p1: previous gate for edge detection
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) gate_p1 <= '0;
      else           gate_p1 <= gate_out;
   end

   assign trigger_out = gate_out & ~gate_p1;
   assign release_out = ~gate_out & gate_p1;

   always_comb begin
      active_count_out = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         active_count_out = active_count_out + CNT_W'(gate_out[i]);
      end
   end

   always_comb begin
      gate_ext = '0;
      trig_ext = '0;
      gate_ext[N_KEYS-1:0] = gate_out;
      trig_ext[N_KEYS-1:0] = trigger_out;
   end

   assign low_full  = lowest_set(gate_ext);
   assign high_full = highest_set(gate_ext);
   assign trig_full = lowest_set(trig_ext);

   // With no gate held the previous index is kept so a release tail can
   // still play the last note.
   always_comb begin
      next_valid = |gate_out;
      next_sel   = note_sel_out;
      case (PRIO_MODE)
         PRIO_LOW:  if (next_valid) next_sel = low_full[SEL_W-1:0];
         PRIO_HIGH: if (next_valid) next_sel = high_full[SEL_W-1:0];
         default: begin
            // A new press always wins over a same-cycle release.
            if (|trigger_out)
               next_sel = trig_full[SEL_W-1:0];
            else if (next_valid && !gate_out[note_sel_out])
               next_sel = low_full[SEL_W-1:0];
         end
      endcase
      next_change = next_valid && (!note_valid_out || (next_sel != note_sel_out));
   end

   // Stage p2: registered selection
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         note_sel_out    <= '0;
         note_valid_out  <= 1'b0;
         note_change_out <= 1'b0;
      end else begin
         note_sel_out    <= next_sel;
         note_valid_out  <= next_valid;
         note_change_out <= next_change;
      end
   end

endmodule

// File: tb/tb_note_priority_decoder.sv
// Directed self-checking bench for note_priority_decoder: three instances
// (24-key PRIO_LOW, 24-key PRIO_LAST, 8-key PRIO_HIGH) share clock and reset.
// Expected timing accounts for the optional debouncer (DB_CYCLES = 4).
module tb_note_priority_decoder;
   import note_pkg::*;

`ifdef NOTE_DEBOUNCE_EN
   localparam int DB = 4;
   localparam int PULSE = 6;
`else
   localparam int DB = 0;
   localparam int PULSE = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] t24;
   logic [7:0]  t8;

   logic [23:0] gate_low, trig_low, rel_low, gate_last, trig_last, rel_last;
   logic [4:0]  sel_low, sel_last, cnt_low, cnt_last;
   logic        val_low, chg_low, val_last, chg_last;
   logic [7:0]  gate_high, trig_high, rel_high;
   logic [2:0]  sel_high;
   logic [3:0]  cnt_high;
   logic        val_high, chg_high;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   note_priority_decoder #(.N_KEYS(24), .DB_CYCLES(4), .PRIO_MODE(PRIO_LOW)) u_low (
      .clk_in(clk), .rst_n_in(rst_n), .touch_status_in(t24),
      .gate_out(gate_low), .trigger_out(trig_low), .release_out(rel_low),
      .note_sel_out(sel_low), .note_valid_out(val_low), .note_change_out(chg_low),
      .active_count_out(cnt_low));

   note_priority_decoder #(.N_KEYS(24), .DB_CYCLES(4), .PRIO_MODE(PRIO_LAST)) u_last (
      .clk_in(clk), .rst_n_in(rst_n), .touch_status_in(t24),
      .gate_out(gate_last), .trigger_out(trig_last), .release_out(rel_last),
      .note_sel_out(sel_last), .note_valid_out(val_last), .note_change_out(chg_last),
      .active_count_out(cnt_last));

   note_priority_decoder #(.N_KEYS(8), .DB_CYCLES(4), .PRIO_MODE(PRIO_HIGH)) u_high (
      .clk_in(clk), .rst_n_in(rst_n), .touch_status_in(t8),
      .gate_out(gate_high), .trigger_out(trig_high), .release_out(rel_high),
      .note_sel_out(sel_high), .note_valid_out(val_high), .note_change_out(chg_high),
      .active_count_out(cnt_high));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_state();
      chk("rst_gate",  32'(gate_last), 32'h0);
      chk("rst_trig",  32'(trig_last), 32'h0);
      chk("rst_rel",   32'(rel_last),  32'h0);
      chk("rst_sel",   32'(sel_last),  32'h0);
      chk("rst_valid", 32'(val_last),  32'h0);
      chk("rst_chg",   32'(chg_last),  32'h0);
      chk("rst_cnt",   32'(cnt_last),  32'h0);
   endtask

   initial begin
      int rise_c, fall_c, ntrig, nrel, nboth, seen;
      rst_n = 1'b0;
      t24   = '0;
      t8    = '0;
      step(3);
      check_reset_state();
      chk("rst_sel_high", 32'(sel_high), 32'h0);

      // Two keys held, lowest priority
      rst_n = 1'b1;
      t24   = 24'h000014;
      step(1 + DB);
      chk("low_gate", 32'(gate_low), 32'h14);
      chk("low_trig", 32'(trig_low), 32'h14);
      chk("low_cnt",  32'(cnt_low),  32'd2);
      step(1);
      chk("low_sel",   32'(sel_low),  32'd2);
      chk("low_valid", 32'(val_low),  32'd1);
      chk("low_chg",   32'(chg_low),  32'd1);
      chk("low_trig_once", 32'(trig_low), 32'h0);
      chk("last_dual_sel", 32'(sel_last), 32'd2);
      step(1);
      chk("low_chg_once", 32'(chg_low), 32'd0);
      t24 = 24'h0;
      step(1 + DB);
      chk("low_rel",  32'(rel_low),  32'h14);
      chk("low_gate0", 32'(gate_low), 32'h0);
      step(1);
      chk("low_valid0", 32'(val_low), 32'd0);
      chk("low_sel_hold", 32'(sel_low), 32'd2);
      chk("low_chg0", 32'(chg_low), 32'd0);

      // Last-note: 5, then 3, then release 3
      t24 = 24'h000020;
      step(1 + DB);
      chk("last_trig5", 32'(trig_last), 32'h20);
      step(1);
      chk("last_sel5", 32'(sel_last), 32'd5);
      chk("last_chg5", 32'(chg_last), 32'd1);
      t24 = 24'h000028;
      step(2 + DB);
      chk("last_sel3", 32'(sel_last), 32'd3);
      chk("last_chg3", 32'(chg_last), 32'd1);
      step(1);
      chk("last_chg3_once", 32'(chg_last), 32'd0);
      t24 = 24'h000020;
      step(1 + DB);
      chk("last_rel3", 32'(rel_last), 32'h08);
      step(1);
      chk("last_back5", 32'(sel_last), 32'd5);
      chk("last_back_chg", 32'(chg_last), 32'd1);
      t24 = 24'h0;
      step(2 + DB);
      chk("last_idle_valid", 32'(val_last), 32'd0);
      chk("last_idle_sel", 32'(sel_last), 32'd5);

      // Simultaneous triggers 7 and 4
      t24 = 24'h000090;
      step(1 + DB);
      chk("last_trig74", 32'(trig_last), 32'h90);
      step(1);
      chk("last_sel4", 32'(sel_last), 32'd4);
      chk("last_chg4", 32'(chg_last), 32'd1);
      t24 = 24'h0;
      step(1 + DB);
      chk("last_rel74", 32'(rel_last), 32'h90);
      chk("last_rel_notrig", 32'(trig_last), 32'h0);
      step(1);
      chk("last_valid0", 32'(val_last), 32'd0);
      chk("last_sel_tail", 32'(sel_last), 32'd4);
      chk("last_nochg", 32'(chg_last), 32'd0);
      chk("last_rel_once", 32'(rel_last), 32'h0);

      // Release of a non-selected key, then press/release on the same edge
      t24 = 24'h000004;
      step(2 + DB);
      t24 = 24'h000044;
      step(2 + DB);
      chk("last_sel6", 32'(sel_last), 32'd6);
      t24 = 24'h000040;
      step(2 + DB);
      chk("last_nonsel_rel", 32'(sel_last), 32'd6);
      chk("last_nonsel_chg", 32'(chg_last), 32'd0);
      t24 = 24'h000001;
      step(2 + DB);
      chk("last_press_wins", 32'(sel_last), 32'd0);
      chk("last_press_chg", 32'(chg_last), 32'd1);
      t24 = 24'h0;
      step(2 + DB);

      // Highest priority on 8 keys
      t8 = 8'h81;
      step(2 + DB);
      chk("high_sel7", 32'(sel_high), 32'd7);
      chk("high_cnt2", 32'(cnt_high), 32'd2);
      t8 = 8'h01;
      step(2 + DB);
      chk("high_sel0", 32'(sel_high), 32'd0);
      chk("high_chg0", 32'(chg_high), 32'd1);
      t8 = 8'h00;

      // Reset in the middle of a held key
      t24 = 24'h000400;
      step(2 + DB);
      chk("hold_sel10", 32'(sel_last), 32'd10);
      rst_n = 1'b0;
      step(2);
      check_reset_state();
      rst_n = 1'b1;
      step(1 + DB);
      chk("rearm_trig10", 32'(trig_last), 32'h400);
      step(1);
      chk("rearm_trig_once", 32'(trig_last), 32'h0);
      chk("rearm_sel10", 32'(sel_last), 32'd10);
      chk("rearm_chg", 32'(chg_last), 32'd1);
      t24 = 24'h0;
      step(2 + DB);

`ifdef NOTE_DEBOUNCE_EN
      // Short glitch must be filtered out
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         t24 = (c < 3) ? 24'h1 : 24'h0;
         step(1);
         if (gate_last[0]) seen = 1;
      end
      chk("db_glitch", 32'(seen), 32'd0);
`endif

      // Key 0 pulse: timing of gate edges and single pulses
      rise_c = -1; fall_c = -1; ntrig = 0; nrel = 0; nboth = 0;
      for (int c = 0; c < 16; c++) begin
         t24 = (c < PULSE) ? 24'h1 : 24'h0;
         step(1);
         if (trig_last[0]) begin ntrig++; rise_c = c; end
         if (rel_last[0])  begin nrel++;  fall_c = c; end
         if (trig_last[0] && rel_last[0]) nboth++;
      end
      chk("pulse_rise_cycle", 32'(rise_c), 32'(DB));
      chk("pulse_fall_cycle", 32'(fall_c), 32'(PULSE + DB));
      chk("pulse_trig_count", 32'(ntrig), 32'd1);
      chk("pulse_rel_count",  32'(nrel),  32'd1);
      chk("pulse_never_both", 32'(nboth), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
